pipeline_memory_access: RTL
===========================

// Module: pipeline_memory_access
// PURPOSE
//  MEM-stage access controller plus MEM/WB pipeline register. Consumes EX/MEM latch outputs.
//  Drives the data-cache request and holds it until dhit.
//  Raises mem_stall to the hazard unit while a request is outstanding.
//  Registers the completed result (ALU value or load data) into the WB stage.
// PARAMETERS
//  DATA_W    32   data/address width
//  MAX_WAIT  255  wait-cycle count at which mem_timeout asserts (8-bit counter, saturating)
// PORTS
//  CLK          in   1       clock, all state on rising edge
//  nRST         in   1       asynchronous active-low reset
//  m_dREN       in   1       MEM-stage instr is a load
//  m_dWEN       in   1       MEM-stage instr is a store
//  m_port_o     in   DATA_W  ALU result: load/store address, or writeback value
//  m_rdat2      in   DATA_W  store data
//  m_MemToReg   in   1       writeback selects load data
//  m_RegWrite   in   1       instr writes register file
//  m_regWSEL    in   5       destination register
//  m_halt       in   1       instr is HALT
//  dhit         in   1       cache completes current request this cycle
//  dmemload     in   DATA_W  load data, valid with dhit
//  dmemREN      out  1       cache read request
//  dmemWEN      out  1       cache write request
//  dmemaddr     out  DATA_W  cache address
//  dmemstore    out  DATA_W  cache write data
//  mem_stall    out  1       freeze IF..EX/MEM; combinational
//  mem_timeout  out  1       sticky: a request waited >= MAX_WAIT cycles
//  w_RegWrite   out  1       registered RF write enable
//  w_regWSEL    out  5       registered destination
//  w_wdat       out  DATA_W  registered writeback data
//  w_halt       out  1       registered halt, sticky once set
// BEHAVIOUR
//  Reset (async, nRST=0):
//   - state=IDLE; wait counter=0.
//   - All registered outputs 0: w_*, mem_timeout.
//   - dmemREN/dmemWEN/mem_stall go 0 immediately, including mid-ACCESS; the request is dropped.
//  Request:
//   - req = (m_dREN|m_dWEN) in IDLE.
//   - m_dWEN has priority if both are set; then dmemREN=0.
//  FSM: IDLE, ACCESS, HALTED.
//   IDLE:
//    - Drive dmemaddr=m_port_o, dmemstore=m_rdat2, REN/WEN from inputs, same cycle (0 extra latency on hit).
//    - Latch addr/data/op.
//    - req & dhit: completes this cycle.
//    - req & !dhit: -> ACCESS.
//    - No req: completes this cycle.
//   ACCESS:
//    - Drive request from the latched registers, so it is stable even if inputs change.
//    - Increment the wait counter each cycle; it saturates.
//    - On dhit: complete, counter=0, -> IDLE.
//   HALTED: entered on completion of m_halt.
//    - Absorbing until reset.
//    - No cache requests; mem_stall=0; w_RegWrite=0; w_halt=1.
//  mem_stall = (IDLE & req & !dhit) | (ACCESS & !dhit).
//  On the completion edge (MEM/WB load):
//   - w_RegWrite <= m_RegWrite.
//   - w_regWSEL <= m_regWSEL.
//   - w_wdat <= m_MemToReg ? dmemload : m_port_o.
//   - w_halt <= m_halt.
//  On a non-completing edge (stall):
//   - Insert bubble: w_RegWrite <= 0, w_halt <= 0, w_regWSEL <= 0, w_wdat <= 0.
//  Stores:
//   - w_RegWrite is taken from the input (0 for stores); no load data is captured.
//  Halt with a pending mem op in the same instr is illegal; halt takes effect without an access.
//  Counter: mem_timeout sets when the counter reaches MAX_WAIT and stays set until reset.
// TESTING
//  1. Load hit:
//     - m_dREN=1, addr=0x40, dhit same cycle, dmemload=0xDEAD_BEEF, MemToReg=1, RegWrite=1, WSEL=5.
//     - mem_stall never 1; next edge w_wdat=0xDEADBEEF, w_regWSEL=5, w_RegWrite=1.
//  2. Load miss:
//     - dhit arrives 3 cycles after request.
//     - mem_stall=1 for 3 cycles; w_RegWrite=0 each stalled cycle.
//     - dmemaddr stays 0x40 while inputs are toggled.
//     - Result is written on the dhit edge.
//  3. Store:
//     - m_dWEN=1, m_dREN=1, addr=0x80, data=0x1234, dhit after 2 cycles.
//     - dmemWEN=1, dmemREN=0, dmemstore=0x1234, stall 2 cycles, then w_RegWrite=0.
//  4. ALU passthrough:
//     - No mem op, port_o=0x7, RegWrite=1.
//     - No stall; w_wdat=0x7 next edge.
//     - Back-to-back 4 instrs give 4 consecutive writebacks.
//  5. Halt:
//     - m_halt=1, then a load on the following instr.
//     - w_halt=1 and sticky; dmemREN never asserts afterward.
//  6. Reset mid-ACCESS and timeout:
//     - nRST low during a miss: dmemREN=0 and mem_stall=0 asynchronously; all w_* are 0.
//     - Separately, withhold dhit for 255 cycles: mem_timeout=1 and it stays 1 after dhit.

Source files
------------

// File: rtl/pipeline_memory_access.sv
// MEM-stage data-cache access controller with the MEM/WB pipeline register.
// Holds a cache request stable until dhit, stalls the front end meanwhile, then writes back.
module pipeline_memory_access #(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              m_dREN,
  input  logic              m_dWEN,
  input  logic [DATA_W-1:0] m_port_o,
  input  logic [DATA_W-1:0] m_rdat2,
  input  logic              m_MemToReg,
  input  logic              m_RegWrite,
  input  logic [4:0]        m_regWSEL,
  input  logic              m_halt,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [DATA_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic              mem_timeout,
  output logic              w_RegWrite,
  output logic [4:0]        w_regWSEL,
  output logic [DATA_W-1:0] w_wdat,
  output logic              w_halt
);

  typedef enum logic [1:0] {IDLE, ACCESS, HALTED} state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] store_q;
  logic              ren_in, wen_in, req, complete;

  // A store wins over a simultaneous load; a halting instruction never touches the cache.
  assign wen_in = m_dWEN & ~m_halt;
  assign ren_in = m_dREN & ~m_dWEN & ~m_halt;
  assign req    = ren_in | wen_in;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ren_d     = ren_q;
    wen_d     = wen_q;
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    dmemaddr  = '0;
    dmemstore = '0;
    mem_stall = 1'b0;
    complete  = 1'b0;
    case (state_q)
      IDLE: begin
        dmemaddr  = m_port_o;
        dmemstore = m_rdat2;
        dmemREN   = ren_in;
        dmemWEN   = wen_in;
        ren_d     = ren_in;
        wen_d     = wen_in;
        if (req && !dhit) begin
          mem_stall = 1'b1;
          state_d   = ACCESS;
          cnt_d     = 8'd1;
        end else begin
          complete = 1'b1;
          if (m_halt) state_d = HALTED;
        end
      end
      ACCESS: begin
        dmemaddr  = addr_q;
        dmemstore = store_q;
        dmemREN   = ren_q;
        dmemWEN   = wen_q;
        if (dhit) begin
          complete = 1'b1;
          cnt_d    = 8'd0;
          state_d  = IDLE;
        end else begin
          mem_stall = 1'b1;
          cnt_d     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Reset must drop an in-flight request without waiting for a clock edge.
    if (!nRST) begin
      dmemREN   = 1'b0;
      dmemWEN   = 1'b0;
      mem_stall = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ren_q       <= ren_d;
      wen_q       <= wen_d;
      mem_timeout <= mem_timeout | (cnt_d == MAX_WAIT_C);
    end
  end

  always_ff @(posedge CLK) begin
    if (state_q == IDLE) begin
      addr_q  <= m_port_o;
      store_q <= m_rdat2;
    end
  end

  // MEM/WB register: load on completion, bubble while stalled, frozen-halt once HALTED.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      w_RegWrite <= 1'b0;
      w_regWSEL  <= 5'd0;
      w_wdat     <= '0;
      w_halt     <= 1'b0;
    end else if (state_q == HALTED) begin
      w_RegWrite <= 1'b0;
      w_halt     <= 1'b1;
    end else if (complete) begin
      w_RegWrite <= m_RegWrite;
      w_regWSEL  <= m_regWSEL;
      w_wdat     <= m_MemToReg ? dmemload : m_port_o;
      w_halt     <= m_halt;
    end else begin
      w_RegWrite <= 1'b0;
      w_regWSEL  <= 5'd0;
      w_wdat     <= '0;
      w_halt     <= 1'b0;
    end
  end

endmodule
